systemfinal_hps_to_control: RTL
===============================

Name: systemfinal_hps_to_control

Overview:
- Avalon-MM slave, HPS-writable control path into the FPGA fabric; the opposite direction of the fabric-to-HPS status input port.
- Holds an output data word that drives the TPU control inputs.
- Launches TPU operations with a start/ack/done handshake, applies a watchdog timeout, and reports busy/done/error status plus an optional interrupt back to the HPS.

Parameters:
- WIDTH, 8, width of out_port and of the DATA/SET/CLEAR registers (1..32).
- RESET_VALUE, 0, out_port value after reset.
- TIMEOUT, 1000, maximum number of RUN-state cycles before ERROR; 0 disables the timeout (counter is 16 bits, TIMEOUT ≤ 65535).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  data word to the fabric
- start  out  1  operation request, held high until acknowledged
- start_ack  in  1  fabric accepted the request
- done_in  in  1  fabric finished the operation (sampled only in RUN)
- irq  out  1  level interrupt to the HPS

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous and active-low.
- While reset_n=0 at a clk edge: out_port=RESET_VALUE, state=IDLE, start=0, readdata=0, irq=0, irq_en=0, timeout counter=0.
- Reset asserted mid-operation aborts the operation silently; no error flag is set.

Register map (write = chipselect & ~write_n):
- 0 DATA: read/write; the write loads writedata[WIDTH-1:0] into out_port.
- 1 CTRL:
  - write bit0 = start, bit1 = abort, bit2 = clear (all self-clearing pulses); bit3 = irq_en (stored).
  - read returns {26'b0, state[1:0], irq_en, error, done, busy} at bits [5:0].
- 2 SET: write only; out_port |= writedata[WIDTH-1:0]. Reads return 0.
- 3 CLEAR: write only; out_port &= ~writedata[WIDTH-1:0]. Reads return 0.

Read path:
- readdata is registered every cycle from the address mux: 1-cycle read latency, no wait states.
- Unused upper bits read 0.

Data protection:
- Writes to DATA, SET and CLEAR are dropped while state is START or RUN, so out_port stays stable during an operation.
- The effect of an accepted write appears on out_port on the cycle after the write.

State machine (state encoding IDLE=0, START=1, RUN=2, FIN=3; FIN carries done or error):
- IDLE: start bit → START.
- START: start=1. When start_ack=1 → RUN, start drops on the next cycle, counter cleared.
- RUN:
  - counter increments each cycle.
  - done_in=1 → FIN with done=1.
  - counter reaching TIMEOUT-1 without done_in (TIMEOUT≠0) → FIN with error=1.
  - done_in on the timeout cycle: done wins.
- FIN:
  - clear bit → IDLE, flags cleared.
  - start bit → START, flags cleared.
  - done_in is ignored.
- Abort in START or RUN → IDLE; start deasserts next cycle; no flag is set. Abort in IDLE or FIN: no effect.
- Simultaneous start and abort in one write: abort wins; a start bit is ignored in START and RUN.
- start_ack in IDLE/RUN/FIN and done_in outside RUN are ignored.
- busy = state ∈ {START, RUN}.
- irq = irq_en & (done | error), registered and updated on the cycle after the state/flag change; it drops on clear, on a restart, or when irq_en is written to 0.

Test Plan:
- Reset: hold reset_n=0 for 3 clk edges with RESET_VALUE=8'hA5 → out_port=A5, readdata=0, start=0, irq=0; a read of CTRL returns 0.
- Register access: write DATA=0x3C, SET=0x81, CLEAR=0x0C → out_port goes 3C, BD, B1 on successive cycles; a read of DATA returns 0xB1 one cycle after the read.
- Normal handshake:
  - write CTRL=0x9 → start=1.
  - start_ack raised after 4 cycles → RUN.
  - done_in after 10 cycles → CTRL reads 0x3A (FIN, irq_en, done) and irq=1.
  - write CTRL=0x4 → state IDLE, irq=0.
- Timeout and restart:
  - TIMEOUT=16, no done_in → error=1 exactly 16 cycles after entering RUN; CTRL reads 0x34 with irq_en=0.
  - start from FIN → START with error cleared.
- Abort and lockout:
  - during RUN, write DATA=0xFF → out_port unchanged.
  - write CTRL=0x3 → IDLE with no flags set; a done_in pulse afterwards has no effect.
- Mid-operation reset: assert reset_n=0 for 1 cycle in RUN → state IDLE, start=0, out_port=RESET_VALUE, a later done_in is ignored.

Source files
------------

// File: rtl/systemfinal_hps_to_control.sv
// HPS-writable control port: data word to the fabric plus a
// start/ack/done operation handshake with watchdog and irq.
module systemfinal_hps_to_control #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             start,
    input  logic             start_ack,
    input  logic             done_in,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);

    state_t      state;
    logic        done;
    logic        error;
    logic        irq_en;
    logic [15:0] cnt;

    logic        wr;
    logic        ctrl_wr;
    logic        go;
    logic        abort;
    logic        clr;
    logic        busy;
    logic [31:0] rd_mux;

    assign wr      = chipselect & ~write_n;
    assign ctrl_wr = wr & (address == 2'd1);
    // abort outranks a start bit in the same write
    assign abort   = ctrl_wr & writedata[1];
    assign go      = ctrl_wr & writedata[0] & ~writedata[1];
    assign clr     = ctrl_wr & writedata[2];
    assign busy    = (state == S_START) | (state == S_RUN);

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = out_port;
            2'd1: rd_mux[5:0] = {state, irq_en, error, done, busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    // data writes are locked out while an operation is in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else if (wr && !busy) begin
            case (address)
                2'd0: out_port <= writedata[WIDTH-1:0];
                2'd2: out_port <= out_port | writedata[WIDTH-1:0];
                2'd3: out_port <= out_port & ~writedata[WIDTH-1:0];
                default: out_port <= out_port;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            start  <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            irq_en <= 1'b0;
            cnt    <= '0;
            irq    <= 1'b0;
        end else begin
            irq <= irq_en & (done | error);
            if (ctrl_wr) begin
                irq_en <= writedata[3];
            end
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_START;
                        start <= 1'b1;
                    end
                end
                S_START: begin
                    if (abort) begin
                        state <= S_IDLE;
                        start <= 1'b0;
                    end else if (start_ack) begin
                        state <= S_RUN;
                        start <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (done_in) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        state <= S_FIN;
                        error <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_FIN: begin
                    if (go) begin
                        state <= S_START;
                        start <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end else if (clr) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
